wr_event_timestamper: RTL and testbench
=======================================

Name: wr_event_timestamper

Overview:
Consumes the White Rabbit core's system clock, PPS pulse and TAI seconds, and timestamps external events as (TAI seconds, clock-cycle phase since the last PPS). It sits directly downstream of the WR core wrapper, in the clk_sys domain.
It also supervises the PPS, reporting lock, missing-PPS and period-error status to software registers.
Captured timestamps are held under a valid/ack handshake until software reads them.

Parameters:
g_clk_freq, 62500000, nominal clk_sys cycles per PPS period (expected PPS period).
g_tol, 2, allowed deviation of the PPS period in cycles (inclusive).
g_lock_count, 3, number of consecutive good periods required to assert lock.

Ports:
clk_sys_i  in  1  WR system clock; the only clock.
rst_i  in  1  asynchronous, active-high reset.
pps_i  in  1  PPS, one-cycle pulse synchronous to clk_sys_i.
tm_tai_i  in  10  current TAI seconds (LSBs) from the WR core.
event_i  in  1  asynchronous external event, rising-edge active.
ack_i  in  1  software acknowledge of the held timestamp.
ts_valid_o  out  1  timestamp held and unread.
ts_tai_o  out  10  captured TAI seconds.
ts_phase_o  out  32  captured cycle phase.
ts_overflow_o  out  16  events lost while a timestamp was held.
pps_locked_o  out  1  PPS period stable.
pps_missing_o  out  1  one-cycle pulse when the PPS is overdue.
pps_err_cnt_o  out  16  bad-period and missing-PPS count.
last_period_o  out  32  most recently measured PPS period in cycles.

Behaviour:
- Reset (asynchronous, applies immediately, also mid-capture):
  - All outputs go to 0; phase is 0; the state machine is IDLE; the synchroniser flops are 0.
- Phase:
  - phase(cycle) = 0 if pps_i is high, else phase(previous cycle) + 1.
  - Phase is registered and saturates at 0xFFFFFFFF.
- Period measurement:
  - On a pps_i cycle, period = phase(previous cycle) + 1.
  - last_period_o is updated on the following cycle.
  - The first PPS after reset sets last_period_o but does not count toward lock or errors.
- Good period:
  - A period is good when |period − g_clk_freq| ≤ g_tol.
  - Each good period increments good_cnt, saturating at g_lock_count.
  - pps_locked_o asserts on the cycle after good_cnt reaches g_lock_count.
- Bad period:
  - pps_locked_o = 0, good_cnt = 0, pps_err_cnt_o + 1 (saturating at 0xFFFF).
- Missing PPS:
  - Triggered when phase reaches g_clk_freq + g_tol + 1 with no PPS.
  - pps_missing_o pulses for 1 cycle, lock is cleared, good_cnt = 0, error count + 1.
  - It fires only once per gap; it re-arms at the next PPS.
  - The late PPS that ends the gap is excluded from period checking.
- Event path:
  - event_i passes through a 2-flop synchroniser, then a rising-edge detect, giving a 1-cycle det pulse.
  - The det pulse occurs 3 cycles after the event_i edge; this latency is fixed and is compensated by software.
- Capture state machine:
  - IDLE:
    - On det: latch ts_tai_o = tm_tai_i and ts_phase_o = phase of the det cycle.
    - Go to HELD; ts_valid_o is high from the next cycle.
  - HELD:
    - ts_valid_o = 1; captured values are frozen.
    - det while HELD: ts_overflow_o + 1 (saturating); the data is not overwritten.
    - ack_i: return to IDLE; ts_valid_o drops on the next cycle.
    - det and ack_i in the same cycle: the ack wins and the event counts as overflow. The FSM must not recapture in that cycle.
  - ack_i in IDLE is ignored.
  - ts_overflow_o clears only on reset.
- Simultaneous PPS and det:
  - The captured phase is 0.
  - The captured TAI is tm_tai_i as sampled in that cycle; no seconds correction is applied in this block.

Decomposition:
- Package wr_ts_pkg:
  - state enum {IDLE, HELD};
  - width constants: C_PHASE_W = 32, C_CNT_W = 16, C_TAI_W = 10.
- One sub-module, wr_event_sync: 2-flop synchroniser plus rising-edge detector, with the same clock and reset.
- PPS supervision and the capture FSM live in the top module.

Test Plan (g_clk_freq = 100, g_tol = 2, g_lock_count = 3):
1. PPS every 100 cycles ×5 → last_period_o = 100; pps_locked_o rises the cycle after the 4th PPS; pps_err_cnt_o = 0.
2. While locked, one PPS period of 97 → pps_locked_o = 0, pps_err_cnt_o = 1; three further 100-cycle periods → relock.
3. PPS withheld → pps_missing_o pulses once when phase = 103; err + 1; lock lost; no second pulse before the next PPS.
4. event_i edge 10 cycles after a PPS with tm_tai_i = 0x155 → ts_valid_o = 1, ts_tai_o = 0x155, ts_phase_o = 13; ack_i → ts_valid_o = 0 the next cycle.
5. Two events while HELD, plus a det coinciding with ack_i → ts_overflow_o = 3; held data unchanged; the FSM returns to IDLE.
6. rst_i asserted while HELD mid-period → all outputs 0 immediately, without a clock edge; after release, the first PPS does not count toward lock.

Source files
------------

// File: rtl/wr_ts_pkg.sv
// Shared types, widths and saturating helpers for the WR event timestamper.
package wr_ts_pkg;

  localparam int C_PHASE_W = 32;
  localparam int C_CNT_W   = 16;
  localparam int C_TAI_W   = 10;

  typedef enum logic {IDLE, HELD} ts_state_t;

  function automatic logic [C_PHASE_W-1:0] sat_inc_phase(input logic [C_PHASE_W-1:0] v);
    return (&v) ? v : v + C_PHASE_W'(1);
  endfunction

  function automatic logic [C_CNT_W-1:0] sat_inc_cnt(input logic [C_CNT_W-1:0] v);
    return (&v) ? v : v + C_CNT_W'(1);
  endfunction

endpackage

// File: rtl/wr_event_sync.sv
// Two-flop synchroniser for the external event plus a registered rising-edge
// detector; det_o is a one-cycle pulse three cycles after the event edge.
module wr_event_sync (
  input  logic clk_sys_i,
  input  logic rst_i,
  input  logic event_i,
  output logic det_o
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
      det_o   <= 1'b0;
    end else begin
      sync1   <= event_i;
      sync2   <= sync1;
      sync2_d <= sync2;
      det_o   <= sync2 & ~sync2_d;
    end
  end

endmodule

// File: rtl/wr_event_timestamper.sv
// Timestamps external events as (TAI seconds, cycles since PPS) and supervises
// the PPS period for lock, missing-pulse and period-error reporting.
//
// state | meaning
// IDLE  | no timestamp held; next detected event is captured
// HELD  | timestamp frozen until ack; further events count as overflow
module wr_event_timestamper
  import wr_ts_pkg::*;
#(
  parameter int unsigned g_clk_freq   = 62500000,
  parameter int unsigned g_tol        = 2,
  parameter int unsigned g_lock_count = 3
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_i,
  input  logic                 pps_i,
  input  logic [C_TAI_W-1:0]   tm_tai_i,
  input  logic                 event_i,
  input  logic                 ack_i,
  output logic                 ts_valid_o,
  output logic [C_TAI_W-1:0]   ts_tai_o,
  output logic [C_PHASE_W-1:0] ts_phase_o,
  output logic [C_CNT_W-1:0]   ts_overflow_o,
  output logic                 pps_locked_o,
  output logic                 pps_missing_o,
  output logic [C_CNT_W-1:0]   pps_err_cnt_o,
  output logic [C_PHASE_W-1:0] last_period_o
);

  localparam logic [C_PHASE_W-1:0] C_PER_MIN =
    (g_clk_freq > g_tol) ? C_PHASE_W'(g_clk_freq - g_tol) : '0;
  localparam logic [C_PHASE_W-1:0] C_PER_MAX = C_PHASE_W'(g_clk_freq + g_tol);
  localparam logic [C_PHASE_W-1:0] C_MISS    = C_PHASE_W'(g_clk_freq + g_tol + 1);
  localparam int                   C_GOOD_W  = $clog2(g_lock_count + 1);
  localparam logic [C_GOOD_W-1:0]  C_LOCK    = C_GOOD_W'(g_lock_count);

  logic                 det;
  logic [C_PHASE_W-1:0] phase_q;
  logic [C_PHASE_W-1:0] phase_now;
  logic [C_PHASE_W-1:0] period;
  logic                 first_seen_q;
  logic                 in_gap_q;
  logic                 miss_now;
  logic                 check_period;
  logic                 period_good;
  logic [C_GOOD_W-1:0]  good_cnt;
  logic [C_GOOD_W-1:0]  good_next;
  logic                 locked_next;
  logic                 err_inc;

  ts_state_t state_q;
  ts_state_t state_d;
  logic      capture;
  logic      ovf_inc;

  wr_event_sync u_event_sync (
    .clk_sys_i (clk_sys_i),
    .rst_i     (rst_i),
    .event_i   (event_i),
    .det_o     (det)
  );

  // phase_now is this cycle's phase; phase_q holds the previous cycle's value
  assign period       = sat_inc_phase(phase_q);
  assign phase_now    = pps_i ? '0 : period;
  assign miss_now     = !pps_i && !in_gap_q && (phase_now == C_MISS);
  assign check_period = pps_i && first_seen_q && !in_gap_q;
  assign period_good  = (period >= C_PER_MIN) && (period <= C_PER_MAX);

  always_comb begin
    good_next   = good_cnt;
    locked_next = pps_locked_o;
    err_inc     = 1'b0;
    if (check_period) begin
      if (period_good) begin
        if (good_cnt != C_LOCK) good_next = good_cnt + C_GOOD_W'(1);
      end else begin
        good_next   = '0;
        locked_next = 1'b0;
        err_inc     = 1'b1;
      end
    end else if (miss_now) begin
      good_next   = '0;
      locked_next = 1'b0;
      err_inc     = 1'b1;
    end
    if (good_next == C_LOCK) locked_next = 1'b1;
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q       <= '0;
      last_period_o <= '0;
      first_seen_q  <= 1'b0;
      in_gap_q      <= 1'b0;
      good_cnt      <= '0;
      pps_locked_o  <= 1'b0;
      pps_missing_o <= 1'b0;
      pps_err_cnt_o <= '0;
    end else begin
      phase_q       <= phase_now;
      pps_missing_o <= miss_now;
      good_cnt      <= good_next;
      pps_locked_o  <= locked_next;
      if (err_inc) pps_err_cnt_o <= sat_inc_cnt(pps_err_cnt_o);
      if (pps_i) begin
        last_period_o <= period;
        first_seen_q  <= 1'b1;
        in_gap_q      <= 1'b0;
      end else if (miss_now) begin
        in_gap_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // in HELD an ack and a det in the same cycle both take effect: release plus overflow
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    ovf_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (det) begin
          capture = 1'b1;
          state_d = HELD;
        end
      end
      HELD: begin
        if (det)   ovf_inc = 1'b1;
        if (ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      ts_tai_o      <= '0;
      ts_phase_o    <= '0;
      ts_overflow_o <= '0;
    end else begin
      if (capture) begin
        ts_tai_o   <= tm_tai_i;
        ts_phase_o <= phase_now;
      end
      if (ovf_inc) ts_overflow_o <= sat_inc_cnt(ts_overflow_o);
    end
  end

  assign ts_valid_o = (state_q == HELD);

endmodule

// File: tb/tb_wr_event_timestamper.sv
// Directed plus randomized bench for wr_event_timestamper against a
// cycle-level behavioural model of the timestamping and PPS supervision rules.
module tb_wr_event_timestamper;

  localparam int     F    = 100;
  localparam int     T    = 2;
  localparam int     L    = 3;
  localparam longint PMAX = 64'hFFFF_FFFF;
  localparam longint CMAX = 65535;

  logic        clk_sys = 1'b0;
  logic        rst     = 1'b1;
  logic        pps     = 1'b0;
  logic        ev      = 1'b0;
  logic        ack     = 1'b0;
  logic [9:0]  tai     = '0;

  logic        ts_valid;
  logic [9:0]  ts_tai;
  logic [31:0] ts_phase;
  logic [15:0] ts_overflow;
  logic        pps_locked;
  logic        pps_missing;
  logic [15:0] pps_err_cnt;
  logic [31:0] last_period;

  int n_vec    = 0;
  int n_bad    = 0;
  int miss_seen = 0;
  bit chk_en   = 0;

  // behavioural model state
  longint m_phase, m_last, m_err, m_ovf, m_tai, m_tsph;
  int     m_good;
  bit     m_first, m_gap, m_locked, m_missing, m_held;
  bit     h1, h2, h3, h4;

  always #5 clk_sys = ~clk_sys;

  wr_event_timestamper #(
    .g_clk_freq   (F),
    .g_tol        (T),
    .g_lock_count (L)
  ) dut (
    .clk_sys_i     (clk_sys),
    .rst_i         (rst),
    .pps_i         (pps),
    .tm_tai_i      (tai),
    .event_i       (ev),
    .ack_i         (ack),
    .ts_valid_o    (ts_valid),
    .ts_tai_o      (ts_tai),
    .ts_phase_o    (ts_phase),
    .ts_overflow_o (ts_overflow),
    .pps_locked_o  (pps_locked),
    .pps_missing_o (pps_missing),
    .pps_err_cnt_o (pps_err_cnt),
    .last_period_o (last_period)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_last = 0; m_err = 0; m_ovf = 0; m_tai = 0; m_tsph = 0;
    m_good = 0; m_first = 0; m_gap = 0; m_locked = 0; m_missing = 0; m_held = 0;
    h1 = 0; h2 = 0; h3 = 0; h4 = 0;
  endtask

  // one clock edge worth of behaviour, using the inputs present in that cycle
  task automatic model_step();
    bit     det;
    longint cur, per;
    if (rst) begin
      model_reset();
      return;
    end
    det = h3 && !h4;
    h4 = h3; h3 = h2; h2 = h1; h1 = ev;
    per = (m_phase + 1 > PMAX) ? PMAX : m_phase + 1;
    cur = pps ? 0 : per;
    m_missing = 0;
    if (pps) begin
      m_last = per;
      if (m_first && !m_gap) begin
        if (per >= F - T && per <= F + T) begin
          if (m_good < L) m_good++;
          if (m_good == L) m_locked = 1;
        end else begin
          m_good = 0; m_locked = 0;
          if (m_err < CMAX) m_err++;
        end
      end
      m_first = 1; m_gap = 0;
    end else if (cur == F + T + 1 && !m_gap) begin
      m_missing = 1; m_good = 0; m_locked = 0; m_gap = 1;
      if (m_err < CMAX) m_err++;
    end
    if (m_held) begin
      if (det && m_ovf < CMAX) m_ovf++;
      if (ack) m_held = 0;
    end else if (det) begin
      m_held = 1; m_tai = tai; m_tsph = cur;
    end
    m_phase = cur;
  endtask

  always @(negedge clk_sys) begin
    if (chk_en) begin
      check("ts_valid",    ts_valid,    m_held);
      check("ts_tai",      ts_tai,      m_tai);
      check("ts_phase",    ts_phase,    m_tsph);
      check("ts_overflow", ts_overflow, m_ovf);
      check("pps_locked",  pps_locked,  m_locked);
      check("pps_missing", pps_missing, m_missing);
      check("pps_err_cnt", pps_err_cnt, m_err);
      check("last_period", last_period, m_last);
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    model_step();
    #1;
    if (pps_missing === 1'b1) miss_seen++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // next PPS lands n cycles after the previous one
  task automatic pps_at(input int n);
    pps = 1'b0;
    repeat (n - 1) tick();
    pps = 1'b1;
    tick();
    pps = 1'b0;
  endtask

  function automatic int pick_period();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      6:       return $urandom_range(90, 97);
      7:       return $urandom_range(103, 106);
      8:       return 150;
      9:       return $urandom_range(1, 5);
      default: return $urandom_range(98, 102);
    endcase
  endfunction

  initial begin
    model_reset();
    tick();
    chk_en = 1;
    tick();
    rst = 1'b0;

    // PPS lock acquisition
    pps_at(10);
    pps_at(100);
    pps_at(100);
    check("lit_unlocked_after_3rd", pps_locked, 1'b0);
    pps_at(100);
    check("lit_locked_after_4th", pps_locked, 1'b1);
    pps_at(100);
    check("lit_last_period_100", last_period, 32'd100);
    check("lit_err_zero", pps_err_cnt, 16'd0);

    // short period breaks lock, three good periods restore it
    pps_at(97);
    check("lit_short_unlock", pps_locked, 1'b0);
    check("lit_short_err", pps_err_cnt, 16'd1);
    pps_at(100);
    pps_at(100);
    check("lit_relock_pending", pps_locked, 1'b0);
    pps_at(100);
    check("lit_relock", pps_locked, 1'b1);

    // withheld PPS
    miss_seen = 0;
    pps = 1'b0;
    idle(150);
    check("lit_missing_once", miss_seen, 1);
    check("lit_missing_err", pps_err_cnt, 16'd2);
    check("lit_missing_unlock", pps_locked, 1'b0);
    pps_at(10);
    check("lit_late_pps_excluded", pps_err_cnt, 16'd2);
    check("lit_late_period", last_period, 32'd160);

    // event 10 cycles after PPS
    tai = 10'h155;
    for (int k = 1; k <= 20; k++) begin
      ev = (k >= 10);
      tick();
    end
    check("lit_cap_valid", ts_valid, 1'b1);
    check("lit_cap_tai", ts_tai, 10'h155);
    check("lit_cap_phase", ts_phase, 32'd13);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("lit_ack_drop", ts_valid, 1'b0);

    // overflow while held, including det coinciding with ack
    ev = 1'b0; idle(4);
    tai = 10'h0AA;
    ev = 1'b1; idle(4);
    tai = 10'h3FF;
    ev = 1'b0; idle(4);
    ev = 1'b1; idle(4);
    ev = 1'b0; idle(4);
    ev = 1'b1; idle(4);
    ev = 1'b0; idle(4);
    ev = 1'b1;
    repeat (3) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("lit_ovf_3", ts_overflow, 16'd3);
    check("lit_ovf_idle", ts_valid, 1'b0);
    check("lit_ovf_tai_kept", ts_tai, 10'h0AA);
    idle(3);
    check("lit_no_recapture", ts_valid, 1'b0);

    // asynchronous reset while HELD
    ev = 1'b0; idle(4);
    ev = 1'b1; idle(5);
    check("lit_held_before_rst", ts_valid, 1'b1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("lit_rst_valid", ts_valid, 1'b0);
    check("lit_rst_tai", ts_tai, 10'h0);
    check("lit_rst_phase", ts_phase, 32'd0);
    check("lit_rst_ovf", ts_overflow, 16'd0);
    check("lit_rst_locked", pps_locked, 1'b0);
    check("lit_rst_missing", pps_missing, 1'b0);
    check("lit_rst_err", pps_err_cnt, 16'd0);
    check("lit_rst_period", last_period, 32'd0);
    ev = 1'b0;
    idle(2);
    rst = 1'b0;
    pps_at(10);
    pps_at(100);
    pps_at(100);
    check("lit_post_rst_unlocked", pps_locked, 1'b0);
    pps_at(100);
    check("lit_post_rst_locked", pps_locked, 1'b1);

    // randomized traffic
    begin
      int since;
      int target;
      since  = 0;
      target = 100;
      for (int c = 0; c < 4000; c++) begin
        since++;
        pps = (since >= target);
        if (pps) begin
          since  = 0;
          target = pick_period();
          tai    = tai + 10'd1;
        end
        if ($urandom_range(0, 5) == 0) ev = ~ev;
        ack = ($urandom_range(0, 4) == 0);
        tick();
      end
    end
    pps = 1'b0; ev = 1'b0; ack = 1'b0;
    idle(5);
    chk_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
